soc_event_token_tx: RTL and testbench
=====================================

// Module: soc_event_token_tx
// PURPOSE
// - SoC-side producer for the SoC->cluster event bus. Generalises the single fixed event link to NB_CH arbitrated sources.
// - Events are written into a BUFFER_DEPTH-slot token ring (one-hot write token, data array); cluster reader returns one-hot read pointer.
// - New: round-robin merge of NB_CH channels, per-channel drop-or-backpressure mode, saturating drop counter, internal read-pointer sync.
// PARAMETERS
// - NB_CH          4   number of event source channels (>=1)
// - EVNT_WIDTH     8   event id width
// - BUFFER_DEPTH   8   token ring slots (>=2); one slot always kept free
// - SYNC_STAGES    2   flops on the read-pointer synchroniser (>=2)
// - DROP_MASK     '0   NB_CH bits; bit c=1 -> channel c drops when full, 0 -> backpressure
// - DROP_CNT_W    16   drop counter width
// PORTS
// - clk_i          in   1                     SoC clock
// - rstn_i         in   1                     asynchronous active-low reset
// - evt_valid_i    in   NB_CH                 per-channel event request
// - evt_data_i     in   NB_CH*EVNT_WIDTH      per-channel event id, channel c at [c*EVNT_WIDTH +: EVNT_WIDTH]
// - evt_ready_o    out  NB_CH                 per-channel accept (event consumed this cycle)
// - events_wt_o    out  BUFFER_DEPTH          one-hot write token (next slot to be written)
// - events_da_o    out  BUFFER_DEPTH*EVNT_WIDTH  slot data array
// - events_rp_i    in   BUFFER_DEPTH          one-hot read pointer from cluster domain (async)
// - full_o         out  1                     ring full (registered-state derived)
// - drop_cnt_o     out  DROP_CNT_W            saturating count of dropped events
// - drop_clr_i     in   1                     synchronous clear of drop_cnt_o
// BEHAVIOUR
// - Reset: events_wt_o=1 (slot 0), events_da_o='0, sync chain=1 (slot 0), drop_cnt_o=0, RR pointer=0; evt_ready_o=0, full_o=0 follow.
// - rp_sync = events_rp_i through SYNC_STAGES flops; no logic before first flop.
// - full = (rotl(wt)==rp_sync); empty (info only) = (wt==rp_sync). Depth usable = BUFFER_DEPTH-1.
// - Arbitration: combinational RR among valid channels; priority starts at rr_ptr; grant g.
// - Write: if any valid and !full -> slot(wt) <= evt_data_i[g], wt <= rotl(wt), rr_ptr <= (g+1)%NB_CH, evt_ready_o[g]=1 same cycle.
// - Data slot and token update on the same edge; reader sees token >=SYNC cycles later, so data is stable when read.
// - Latency: accepted at edge N -> events_wt_o advanced and events_da_o slot valid from cycle N+1.
// - Non-granted channels: ready=0 while !full (held, no loss).
// - Full: backpressure channels ready=0; every valid DROP_MASK channel gets ready=1 and event discarded; no slot written, wt unchanged.
// - drop_cnt += popcount(dropped) per cycle, saturating at all-ones; drop_clr_i wins over same-cycle increment (result 0).
// - rr_ptr unchanged when nothing written. Full asserted the cycle after the write that fills, cleared 1 sync latency after rp moves.
// - Wrap: rotl(wt) of MSB-set token -> bit 0. Non-one-hot rp_sync is undefined input; bench must never drive it.
// - Reset mid-operation: all state cleared immediately (async); buffered events lost; cluster reader reset concurrently by system.
// - Valid/data of a held channel must stay stable until ready (assertion on input).
// STRUCTURE
// - soc_evt_pkg: rotl_onehot() function, evt_id_t typedef (logic [EVNT_WIDTH-1:0] via parameterised struct not used; plain width), popcount fn.
// - Sub-module soc_evt_rr_arb (NB_CH req, rr_ptr in, one-hot grant + index out, combinational).
// - Top: sync chain, token/data regs, drop counter, rr_ptr reg. ~200 lines.
// TESTING
// - Reset: after rstn_i low->high, wt=8'h01, da='0, drop_cnt=0, ready=0 with no valid.
// - Single ch0 event 8'hA5, rp=8'h01 -> ready[0]=1 one cycle, next cycle wt=8'h02, slot0=8'hA5.
// - All 4 channels valid continuously, rp never moves -> grants ch0,1,2,3,0,1,2 then full_o=1 after 7 writes, all ready=0.
// - Full with DROP_MASK=4'b0100, ch2 and ch3 valid 5 cycles -> ch2 ready=1 each cycle, drop_cnt=5, ch3 held, wt unchanged.
// - Wrap: reader advances rp one slot per event, 20 events on ch1 -> wt cycles 0x01..0x80..0x01, data in order, no drops.
// - drop_cnt=16'hFFFF plus drop -> stays FFFF; drop_clr_i with same-cycle drop -> 0; rstn_i low mid-burst -> wt=8'h01 async.

Source files
------------

// File: rtl/soc_evt_pkg.sv
// soc_evt_pkg: one-hot rotate and popcount helpers for the SoC event token ring
package soc_evt_pkg;
  localparam int MAX_W = 64;
  localparam int MAX_LOG = 6;
  function automatic logic [MAX_W-1:0] rotl_onehot(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) if (i < w) r[MAX_LOG'((i + 1) % w)] = v[i];
    return r;
  endfunction
  function automatic logic [7:0] popcount(input logic [MAX_W-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < MAX_W; i++) c = c + 8'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/soc_evt_rr_arb.sv
// soc_evt_rr_arb: combinational round-robin arbiter, priority starting at rr_ptr
module soc_evt_rr_arb #(
  parameter int NB_CH = 4,
  localparam int IDX_W = NB_CH > 1 ? $clog2(NB_CH) : 1
) (
  input  logic [NB_CH-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NB_CH-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);
  always_comb begin
    logic [IDX_W-1:0] c;
    c = '0;
    gnt = '0;
    gnt_idx = '0;
    for (int i = NB_CH - 1; i >= 0; i--) begin
      c = IDX_W'((int'(rr_ptr) + i) % NB_CH);
      if (req[c]) begin
        gnt = '0;
        gnt[c] = 1'b1;
        gnt_idx = c;
      end
    end
  end
endmodule

// File: rtl/soc_event_token_tx.sv
// soc_event_token_tx: arbitrated multi-channel producer into a one-hot token ring
module soc_event_token_tx import soc_evt_pkg::*; #(
  parameter int NB_CH = 4,
  parameter int EVNT_WIDTH = 8,
  parameter int BUFFER_DEPTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [NB_CH-1:0] DROP_MASK = '0,
  parameter int DROP_CNT_W = 16
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  input  logic [NB_CH-1:0]                   evt_valid_i,
  input  logic [NB_CH*EVNT_WIDTH-1:0]        evt_data_i,
  output logic [NB_CH-1:0]                   evt_ready_o,
  output logic [BUFFER_DEPTH-1:0]            events_wt_o,
  output logic [BUFFER_DEPTH*EVNT_WIDTH-1:0] events_da_o,
  input  logic [BUFFER_DEPTH-1:0]            events_rp_i,
  output logic                               full_o,
  output logic [DROP_CNT_W-1:0]              drop_cnt_o,
  input  logic                               drop_clr_i
);
  localparam int IDX_W = NB_CH > 1 ? $clog2(NB_CH) : 1;
  localparam int CW = DROP_CNT_W + 1;
  logic [SYNC_STAGES-1:0][BUFFER_DEPTH-1:0] rp_q;
  logic [BUFFER_DEPTH-1:0] wt_q, wt_nxt, rp_sync;
  logic [BUFFER_DEPTH*EVNT_WIDTH-1:0] da_q;
  logic [IDX_W-1:0] rr_q, gnt_idx;
  logic [NB_CH-1:0] gnt, dropped;
  logic [DROP_CNT_W-1:0] cnt_q;
  logic [DROP_CNT_W:0] cnt_sum;
  logic [EVNT_WIDTH-1:0] wr_data;
  logic full, wr;
  soc_evt_rr_arb #(.NB_CH(NB_CH)) u_arb (
    .req    (evt_valid_i),
    .rr_ptr (rr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx)
  );
  // one slot stays free so a full ring never looks identical to an empty one
  assign rp_sync = rp_q[SYNC_STAGES-1];
  assign wt_nxt = BUFFER_DEPTH'(rotl_onehot(MAX_W'(wt_q), BUFFER_DEPTH));
  assign full = wt_nxt == rp_sync;
  assign wr = |evt_valid_i && !full;
  assign dropped = full ? evt_valid_i & DROP_MASK : '0;
  assign wr_data = evt_data_i[gnt_idx*EVNT_WIDTH +: EVNT_WIDTH];
  assign cnt_sum = {1'b0, cnt_q} + CW'(popcount(MAX_W'(dropped)));
  assign evt_ready_o = full ? dropped : gnt;
  assign events_wt_o = wt_q;
  assign events_da_o = da_q;
  assign full_o = full;
  assign drop_cnt_o = cnt_q;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rp_q <= {SYNC_STAGES{BUFFER_DEPTH'(1)}};
      wt_q <= BUFFER_DEPTH'(1);
      da_q <= '0;
      rr_q <= '0;
      cnt_q <= '0;
    end else begin
      rp_q <= {rp_q[SYNC_STAGES-2:0], events_rp_i};
      if (wr) begin
        wt_q <= wt_nxt;
        rr_q <= gnt_idx == IDX_W'(NB_CH - 1) ? '0 : gnt_idx + IDX_W'(1);
        for (int s = 0; s < BUFFER_DEPTH; s++) if (wt_q[s]) da_q[s*EVNT_WIDTH +: EVNT_WIDTH] <= wr_data;
      end
      cnt_q <= drop_clr_i ? '0 : cnt_sum[DROP_CNT_W] ? '1 : cnt_sum[DROP_CNT_W-1:0];
    end
  end
  // a channel left waiting must keep its request and id until accepted
  for (genvar c = 0; c < NB_CH; c++) begin : g_hold
    a_hold: assert property (@(posedge clk_i) disable iff (!rstn_i)
      evt_valid_i[c] && !evt_ready_o[c] |=> evt_valid_i[c] && $stable(evt_data_i[c*EVNT_WIDTH +: EVNT_WIDTH]));
  end
endmodule

// File: tb/tb_soc_event_token_tx.sv
// tb_soc_event_token_tx: directed vectors for backpressure, drop and saturation variants
module tb_soc_event_token_tx;
  typedef struct {
    logic [3:0] valid;
    logic [3:0] ready;
    logic [7:0] wt;
    logic       full;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [3:0] valid [3];
  logic [3:0] ready [3];
  logic [31:0] data [3];
  logic [7:0] wt [3];
  logic [7:0] rp [3];
  logic [63:0] da [3];
  logic [15:0] dcnt [3];
  logic full [3];
  logic clr [3];
  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl [9];
  always #5 clk = ~clk;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    soc_event_token_tx #(
      .NB_CH(4), .EVNT_WIDTH(8), .BUFFER_DEPTH(8), .SYNC_STAGES(2),
      .DROP_MASK(k == 0 ? 4'b0000 : k == 1 ? 4'b0100 : 4'b1111), .DROP_CNT_W(16)
    ) u_dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .evt_valid_i(valid[k]),
      .evt_data_i (data[k]),
      .evt_ready_o(ready[k]),
      .events_wt_o(wt[k]),
      .events_da_o(da[k]),
      .events_rp_i(rp[k]),
      .full_o     (full[k]),
      .drop_cnt_o (dcnt[k]),
      .drop_clr_i (clr[k])
    );
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      valid[k] = '0;
      data[k] = '0;
      rp[k] = 8'h01;
      clr[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{4'hF, 4'h1, 8'h01, 1'b0};
    tbl[1] = '{4'hF, 4'h2, 8'h02, 1'b0};
    tbl[2] = '{4'hF, 4'h4, 8'h04, 1'b0};
    tbl[3] = '{4'hF, 4'h8, 8'h08, 1'b0};
    tbl[4] = '{4'hF, 4'h1, 8'h10, 1'b0};
    tbl[5] = '{4'hF, 4'h2, 8'h20, 1'b0};
    tbl[6] = '{4'hF, 4'h4, 8'h40, 1'b0};
    tbl[7] = '{4'hF, 4'h0, 8'h80, 1'b1};
    tbl[8] = '{4'hF, 4'h0, 8'h80, 1'b1};
    do_reset();
    #1;
    chk("rst_wt", 64'(wt[0]), 64'h01);
    chk("rst_da", da[0], 64'h0);
    chk("rst_dcnt", 64'(dcnt[0]), 64'h0);
    chk("rst_ready", 64'(ready[0]), 64'h0);
    chk("rst_full", 64'(full[0]), 64'h0);
    valid[0] = 4'b0001;
    data[0] = 32'h0000_00A5;
    #1;
    chk("single_ready", 64'(ready[0]), 64'h1);
    @(negedge clk);
    valid[0] = 4'b0000;
    #1;
    chk("single_wt", 64'(wt[0]), 64'h02);
    chk("single_slot0", 64'(da[0][7:0]), 64'hA5);
    chk("single_ready_off", 64'(ready[0]), 64'h0);
    do_reset();
    data[0] = 32'h1312_1110;
    for (int i = 0; i < 9; i++) begin
      valid[0] = tbl[i].valid;
      #1;
      chk($sformatf("rr%0d_ready", i), 64'(ready[0]), 64'(tbl[i].ready));
      chk($sformatf("rr%0d_wt", i), 64'(wt[0]), 64'(tbl[i].wt));
      chk($sformatf("rr%0d_full", i), 64'(full[0]), 64'(tbl[i].full));
      @(negedge clk);
    end
    for (int s = 0; s < 7; s++) chk($sformatf("rr_slot%0d", s), 64'(da[0][s*8 +: 8]), 64'(8'h10 + 8'(s % 4)));
    #3;
    rstn = 1'b0;
    #1;
    chk("async_rst_wt", 64'(wt[0]), 64'h01);
    chk("async_rst_full", 64'(full[0]), 64'h0);
    chk("async_rst_da", da[0], 64'h0);
    do_reset();
    data[1] = 32'h4433_2211;
    for (int i = 0; i < 7; i++) begin
      valid[1] = 4'b0001;
      #1;
      chk($sformatf("fill%0d_ready", i), 64'(ready[1]), 64'h1);
      @(negedge clk);
    end
    valid[1] = 4'b1100;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("drop%0d_ready", i), 64'(ready[1]), 64'h4);
      chk($sformatf("drop%0d_wt", i), 64'(wt[1]), 64'h80);
      chk($sformatf("drop%0d_full", i), 64'(full[1]), 64'h1);
      @(negedge clk);
    end
    #1;
    chk("drop_cnt5", 64'(dcnt[1]), 64'h5);
    clr[1] = 1'b1;
    #1;
    chk("clr_ready", 64'(ready[1]), 64'h4);
    @(negedge clk);
    clr[1] = 1'b0;
    valid[1] = 4'b1000;
    rp[1] = 8'h02;
    #1;
    chk("clr_wins", 64'(dcnt[1]), 64'h0);
    chk("sync0_full", 64'(full[1]), 64'h1);
    chk("sync0_ready", 64'(ready[1]), 64'h0);
    @(negedge clk);
    #1;
    chk("sync1_full", 64'(full[1]), 64'h1);
    chk("sync1_ready", 64'(ready[1]), 64'h0);
    @(negedge clk);
    #1;
    chk("sync2_full", 64'(full[1]), 64'h0);
    chk("sync2_ready", 64'(ready[1]), 64'h8);
    @(negedge clk);
    valid[1] = 4'b0000;
    #1;
    chk("held_wrap_wt", 64'(wt[1]), 64'h01);
    chk("held_slot7", 64'(da[1][63:56]), 64'h44);
    chk("held_dcnt", 64'(dcnt[1]), 64'h0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      valid[2] = 4'b0001;
      @(negedge clk);
    end
    valid[2] = 4'b1111;
    repeat (16383) @(negedge clk);
    #1;
    chk("sat_fffc", 64'(dcnt[2]), 64'hFFFC);
    @(negedge clk);
    #1;
    chk("sat_ffff", 64'(dcnt[2]), 64'hFFFF);
    @(negedge clk);
    #1;
    chk("sat_hold", 64'(dcnt[2]), 64'hFFFF);
    chk("sat_ready", 64'(ready[2]), 64'hF);
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    valid[2] = 4'b0000;
    #1;
    chk("sat_clr", 64'(dcnt[2]), 64'h0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ev, exp_wt;
      ev = 8'h40 + 8'(i);
      exp_wt = 8'(1 << ((i + 1) % 8));
      valid[0] = 4'b0010;
      data[0] = {16'h0, ev, 8'h0};
      #1;
      chk($sformatf("wrap%0d_ready", i), 64'(ready[0]), 64'h2);
      @(negedge clk);
      valid[0] = 4'b0000;
      #1;
      chk($sformatf("wrap%0d_wt", i), 64'(wt[0]), 64'(exp_wt));
      chk($sformatf("wrap%0d_slot", i), 64'(da[0][(i % 8)*8 +: 8]), 64'(ev));
      rp[0] = exp_wt;
      @(negedge clk);
    end
    #1;
    chk("wrap_dcnt", 64'(dcnt[0]), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
